uart_tx_scheduler: RTL

- Shares the single 8N1 UART transmitter among NUM_REQ requesters. Examples: LCD status reporter, debug dumper, command echo.
- Each requester presents a packet one byte at a time, with a last-byte flag.
- The scheduler grants the transmitter round-robin per packet, feeds bytes via the transmitter's begin/busy/done handshake, and aborts a packet if the owner stalls.
- Sits between the requesters and the UART transmitter; it is the only driver of the transmitter's begin/data inputs.

---
 rtl/uart_tx_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin, per-packet owner of a shared 8N1 transmitter; feeds bytes over begin/busy/done.
// All outputs registered; an owner that idles mid-packet for HOLD_TIMEOUT clocks is aborted.
module uart_tx_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int HOLD_TIMEOUT = 2000
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [8*NUM_REQ-1:0] i_reqData,
   input  logic [NUM_REQ-1:0]   i_reqLast,
   output logic [NUM_REQ-1:0]   o_reqAck,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic [NUM_REQ-1:0]   o_abort,
   output logic                 o_busy,
   output logic                 o_txBegin,
   output logic [7:0]           o_txData,
   input  logic                 i_txBusy,
   input  logic                 i_txDone
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      s_IDLE,
      s_LOAD,
      s_WAIT_BUSY,
      s_WAIT_DONE,
      s_HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_owner_q, last_owner_d;
   logic               last_flag_q, last_flag_d;
   logic [15:0]        hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
   logic [NUM_REQ-1:0] abort_q, abort_d;
   logic               busy_q, busy_d;
   logic               tx_begin_q, tx_begin_d;
   logic [7:0]         tx_data_q, tx_data_d;

   logic               do_load;
   logic [IDX_W-1:0]   load_idx;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_found;
   int                 rr_cand;
   logic [7:0]         load_byte;

   // Round-robin search starts just above the previous owner and wraps.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = last_owner_q;
      rr_cand  = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         rr_cand = (int'(last_owner_q) + i) % NUM_REQ;
         if (!rr_found && i_req[IDX_W'(rr_cand)]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(rr_cand);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      last_flag_d  = last_flag_q;
      hold_cnt_d   = hold_cnt_q;
      req_ack_d    = '0;
      abort_d      = '0;
      tx_begin_d   = 1'b0;
      tx_data_d    = tx_data_q;
      do_load      = 1'b0;
      load_idx     = owner_q;
      load_byte    = 8'h00;

      case (state_q)
         s_IDLE: begin
            if (rr_found && !i_txBusy) begin
               owner_d          = rr_idx;
               grant_d          = '0;
               grant_d[rr_idx]  = 1'b1;
               load_idx         = rr_idx;
               do_load          = 1'b1;
            end
         end
         s_LOAD: begin
            state_d = s_WAIT_BUSY;
         end
         s_WAIT_BUSY: begin
            if (i_txBusy) begin
               state_d = s_WAIT_DONE;
            end
         end
         s_WAIT_DONE: begin
            if (i_txDone) begin
               if (last_flag_q) begin
                  last_owner_d = owner_q;
                  grant_d      = '0;
                  state_d      = s_IDLE;
               end else if (i_req[owner_q]) begin
                  do_load = 1'b1;
               end else begin
                  hold_cnt_d = 16'd0;
                  state_d    = s_HOLD;
               end
            end
         end
         s_HOLD: begin
            if (i_req[owner_q]) begin
               do_load = 1'b1;
            end else if (hold_cnt_q == 16'(HOLD_TIMEOUT - 1)) begin
               abort_d[owner_q] = 1'b1;
               last_owner_d     = owner_q;
               grant_d          = '0;
               state_d          = s_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = s_IDLE;
         end
      endcase

      for (int k = 0; k < NUM_REQ; k++) begin
         if (load_idx == IDX_W'(k)) begin
            load_byte = i_reqData[8*k +: 8];
         end
      end

      // Begin, data and ack are launched together so they are all high during s_LOAD.
      if (do_load) begin
         state_d             = s_LOAD;
         tx_begin_d          = 1'b1;
         tx_data_d           = load_byte;
         req_ack_d[load_idx] = 1'b1;
         last_flag_d         = i_reqLast[load_idx];
      end

      busy_d = (state_d != s_IDLE);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= s_IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
         last_flag_q  <= 1'b0;
         hold_cnt_q   <= 16'd0;
         req_ack_q    <= '0;
         abort_q      <= '0;
         busy_q       <= 1'b0;
         tx_begin_q   <= 1'b0;
         tx_data_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         last_flag_q  <= last_flag_d;
         hold_cnt_q   <= hold_cnt_d;
         req_ack_q    <= req_ack_d;
         abort_q      <= abort_d;
         busy_q       <= busy_d;
         tx_begin_q   <= tx_begin_d;
         tx_data_q    <= tx_data_d;
      end
   end

   assign o_reqAck  = req_ack_q;
   assign o_grant   = grant_q;
   assign o_abort   = abort_q;
   assign o_busy    = busy_q;
   assign o_txBegin = tx_begin_q;
   assign o_txData  = tx_data_q;

endmodule
